// File: rtl/iob_cache_axi_read_arbiter.sv
// iob_cache_axi_read_arbiter
// Lets two burst requesters, such as the I-cache and D-cache refill ports,
// share one AXI4 read channel (AR + R). Arbitration is round-robin. A grant is
// held for one whole transaction: from AR acceptance up to the R beat that
// carries rlast. Only one transaction is outstanding at a time, and the AXI ID
// passes through unchanged.
//
// Optional build macro IOB_CACHE_ARB_ERR_CNT_EN adds the err_cnt/err_clr ports.
// err_cnt is a saturating count of completed bursts that returned at least one
// beat with an error response.
module iob_cache_axi_read_arbiter #(
    parameter int BE_ADDR_W = 32,
    parameter int BE_DATA_W = 32,
    parameter int AXI_ID_W  = 1
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 m0_arvalid,
    input  logic [BE_ADDR_W-1:0] m0_araddr,
    input  logic [7:0]           m0_arlen,
    input  logic [2:0]           m0_arsize,
    input  logic [1:0]           m0_arburst,
    input  logic [AXI_ID_W-1:0]  m0_arid,
    output logic                 m0_arready,
    output logic                 m0_rvalid,
    output logic [BE_DATA_W-1:0] m0_rdata,
    output logic [1:0]           m0_rresp,
    output logic                 m0_rlast,
    input  logic                 m0_rready,

    input  logic                 m1_arvalid,
    input  logic [BE_ADDR_W-1:0] m1_araddr,
    input  logic [7:0]           m1_arlen,
    input  logic [2:0]           m1_arsize,
    input  logic [1:0]           m1_arburst,
    input  logic [AXI_ID_W-1:0]  m1_arid,
    output logic                 m1_arready,
    output logic                 m1_rvalid,
    output logic [BE_DATA_W-1:0] m1_rdata,
    output logic [1:0]           m1_rresp,
    output logic                 m1_rlast,
    input  logic                 m1_rready,

    output logic                 axi_arvalid,
    output logic [BE_ADDR_W-1:0] axi_araddr,
    output logic [7:0]           axi_arlen,
    output logic [2:0]           axi_arsize,
    output logic [1:0]           axi_arburst,
    output logic [AXI_ID_W-1:0]  axi_arid,
    input  logic                 axi_arready,
    input  logic                 axi_rvalid,
    input  logic [BE_DATA_W-1:0] axi_rdata,
    input  logic [1:0]           axi_rresp,
    input  logic                 axi_rlast,
    output logic                 axi_rready,

    output logic                 busy
`ifdef IOB_CACHE_ARB_ERR_CNT_EN
    ,
    input  logic                 err_clr,
    output logic [15:0]          err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   grant, grant_nxt;
    logic   last,  last_nxt;

    logic   sel_arvalid;
    logic   sel_rready;
    logic   ar_done;
    logic   r_done;

    assign sel_arvalid = grant ? m1_arvalid : m0_arvalid;
    assign sel_rready  = grant ? m1_rready  : m0_rready;
    assign ar_done     = (state == ADDR) & sel_arvalid & axi_arready;
    assign r_done      = (state == DATA) & axi_rvalid & sel_rready & axi_rlast;

    // State, grant and round-robin history registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            grant <= 1'b0;
            last  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values.
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant through ADDR and DATA.
    always_comb begin
        // NOTE: defaults come first, so no path leaves a variable unassigned and no latch is inferred.
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (m0_arvalid && m1_arvalid) begin
                    grant_nxt = ~last;
                    state_nxt = ADDR;
                end else if (m0_arvalid) begin
                    grant_nxt = 1'b0;
                    state_nxt = ADDR;
                end else if (m1_arvalid) begin
                    grant_nxt = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (ar_done) begin
                    last_nxt  = grant;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (r_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // AR fields follow the grant in every state. Only arvalid qualifies them.
    assign axi_araddr  = grant ? m1_araddr  : m0_araddr;
    assign axi_arlen   = grant ? m1_arlen   : m0_arlen;
    assign axi_arsize  = grant ? m1_arsize  : m0_arsize;
    assign axi_arburst = grant ? m1_arburst : m0_arburst;
    assign axi_arid    = grant ? m1_arid    : m0_arid;
    assign axi_arvalid = (state == ADDR) & sel_arvalid;

    assign m0_arready  = (state == ADDR) & ~grant & axi_arready;
    assign m1_arready  = (state == ADDR) &  grant & axi_arready;

    // R data and response go to both requesters. Only the granted one sees valid or last.
    assign m0_rdata    = axi_rdata;
    assign m1_rdata    = axi_rdata;
    assign m0_rresp    = axi_rresp;
    assign m1_rresp    = axi_rresp;
    assign m0_rvalid   = (state == DATA) & ~grant & axi_rvalid;
    assign m1_rvalid   = (state == DATA) &  grant & axi_rvalid;
    assign m0_rlast    = (state == DATA) & ~grant & axi_rlast;
    assign m1_rlast    = (state == DATA) &  grant & axi_rlast;
    assign axi_rready  = (state == DATA) & sel_rready;

    assign busy        = (state != IDLE);

`ifdef IOB_CACHE_ARB_ERR_CNT_EN
    logic err_seen;
    logic beat_err;

    assign beat_err = (state == DATA) & axi_rvalid & axi_rready & (axi_rresp != 2'b00);

    // Sticky per-burst error flag and saturating counter of bursts with errors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_seen <= 1'b0;
            err_cnt  <= 16'd0;
        end else begin
            if (state == IDLE && state_nxt == ADDR) err_seen <= 1'b0;
            else if (beat_err)                      err_seen <= 1'b1;

            if (err_clr)
                err_cnt <= 16'd0;
            else if (r_done && (err_seen || beat_err) && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/iob_cache_axi_read_arbiter.md
Name: iob_cache_axi_read_arbiter

Overview:
- Shares one back-end AXI4 read channel (AR + R) between two burst requesters, for example an I-cache and a D-cache line-refill channel.
- Arbitration is round-robin, and the grant is locked for a whole transaction: from AR acceptance until the R beat carrying rlast.
- Sits between the cache read channels and the external memory AXI port.
- Only one outstanding transaction at a time; the AXI ID is passed through unchanged.

Parameters:
- BE_ADDR_W, 32, back-end AXI address width.
- BE_DATA_W, 32, back-end AXI data width.
- AXI_ID_W, 1, AXI ID width.

Ports:
- clk  in  1  clock; clk is the only clock.
- reset  in  1  reset, asynchronous, active-high.
- mN_arvalid, N=0,1  in  1  requester N AR valid.
- mN_araddr  in  BE_ADDR_W  requester N burst address.
- mN_arlen  in  8  requester N burst length.
- mN_arsize  in  3  requester N beat size.
- mN_arburst  in  2  requester N burst type.
- mN_arid  in  AXI_ID_W  requester N ID.
- mN_arready  out  1  AR accepted for requester N.
- mN_rvalid  out  1  R beat valid to requester N.
- mN_rdata  out  BE_DATA_W  R data to requester N.
- mN_rresp  out  2  R response to requester N.
- mN_rlast  out  1  last beat to requester N.
- mN_rready  in  1  requester N R ready.
- axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid  out  widths as above  downstream AR channel.
- axi_arready  in  1  downstream AR ready.
- axi_rvalid  in  1  downstream R valid.
- axi_rdata  in  BE_DATA_W  downstream R data.
- axi_rresp  in  2  downstream R response.
- axi_rlast  in  1  downstream R last.
- axi_rready  out  1  downstream R ready.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Registers:
  - state: IDLE, ADDR, DATA.
  - grant: 1 bit.
  - last: 1 bit, the requester served most recently.
- Reset (asynchronous): state=IDLE, grant=0, last=1, so m0 wins the first tie.
- Output reset values: all outputs 0 (axi_arvalid, axi_rready, mN_arready, mN_rvalid, busy); data outputs follow the mux.
- IDLE:
  - No requester arvalid: stay in IDLE.
  - Only mK_arvalid: grant<=K, go to ADDR.
  - Both: grant<=~last, go to ADDR.
  - Decision is registered; 1 cycle of arbitration latency. AR is never driven in IDLE.
- ADDR:
  - axi_ar* = fields of m[grant]; axi_arvalid = m[grant]_arvalid.
  - m[grant]_arready = axi_arready.
  - On axi_arvalid & axi_arready: last<=grant, go to DATA.
  - Requester must hold arvalid and fields stable until handshake (AXI rule); otherwise wait.
- DATA:
  - m[grant]_rvalid/rdata/rresp/rlast = axi_r*; axi_rready = m[grant]_rready.
  - On axi_rvalid & axi_rready & axi_rlast: go to IDLE. Next grant possible 1 cycle later, giving 1 idle cycle between bursts.
  - Error rresp is forwarded unchanged; no retry. Retry is the requester's job.
- Non-granted requester, and both requesters in IDLE: arready=0, rvalid=0, rlast=0. R data/resp buses may be driven for both requesters.
- Downstream AR fields are muxed by grant in every state; only arvalid qualifies them.
- Single-beat bursts (arlen=0): rlast on the first beat ends DATA.
- A new arvalid from the granted requester during DATA is ignored until IDLE.
- Reset mid-burst: immediate return to IDLE. The downstream slave is expected to be reset on the same reset.
- Purely combinational paths: axi_arready->mN_arready, axi_r*->mN_r*, mN_rready->axi_rready. No added latency on beats.

Optional Feature:
- Macro: IOB_CACHE_ARB_ERR_CNT_EN.
- When defined:
  - Adds output err_cnt, 16 bits, reset 0.
  - Increments once per completed burst in which any beat had rresp!=2'b00. Tracked with a sticky flag cleared on entering ADDR.
  - Saturates at 16'hFFFF.
  - Adds input err_clr, 1 bit; synchronous clear, with priority over increment in the same cycle.
- When undefined: no err_cnt/err_clr ports, no flag, no counter.

Test Plan:
- Single requester: after reset, m0 requests araddr=0x100, arlen=3; axi_arready after 2 cycles; 4 beats.
  - Expect axi_araddr=0x100 in ADDR.
  - Expect m0 to receive 4 beats, with rlast on the 4th.
  - Expect busy low 1 cycle after the last beat.
  - Expect m1_rvalid=0 throughout.
- Simultaneous requests after reset: m0 and m1 both request in the same cycle.
  - Expect m0 served first.
  - Expect m1 granted on the cycle after m0's rlast beat.
  - Next simultaneous pair goes to m0 again only after m1 has been served (round-robin alternation checked over 6 bursts).
- Back-pressure: m1 granted, m1_rready toggling 1/0 each cycle, arlen=7.
  - Expect axi_rready to mirror m1_rready.
  - Expect exactly 8 beats delivered, with no loss or duplication.
- Single beat: arlen=0, rlast on the first beat.
  - Expect return to IDLE after 1 beat.
  - Expect the pending other requester granted 1 cycle later.
- Reset mid-burst: assert reset after beat 2 of 8.
  - Expect all outputs 0 immediately.
  - Expect m0 to win the next tie (last=1).
- IOB_CACHE_ARB_ERR_CNT_EN defined:
  - 3 bursts, of which bursts 1 and 3 have one beat each with rresp=2'b10: expect err_cnt=2.
  - err_clr asserted together with an erroring burst end: expect err_cnt=0.
